// File: rtl/fft_dif_iter.sv
// Iterative radix-2 DIF FFT/IFFT: parallel frame capture, one time-shared butterfly
// per cycle over log2(N) stages, bit-reversal-corrected natural-order outputs.
module fft_dif_iter #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 32,
  parameter int TW_FRAC  = 14
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             inv,
  input  logic                             scale,
  input  logic [N_POINTS-1:0][DATA_W-1:0]  data_in_R,
  input  logic [N_POINTS-1:0][DATA_W-1:0]  data_in_I,
  output logic                             busy,
  output logic                             done,
  output logic [N_POINTS-1:0][DATA_W-1:0]  Real,
  output logic [N_POINTS-1:0][DATA_W-1:0]  Imag
);
  localparam int  L    = $clog2(N_POINTS);
  localparam int  HALF = N_POINTS / 2;
  localparam int  TW_W = TW_FRAC + 2;
  localparam int  SW   = (L > 1) ? $clog2(L) : 1;
  localparam int  EW   = DATA_W + 1;
  localparam int  PW   = EW + TW_W + 1;
  localparam real PI   = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] mem_r [N_POINTS];
  logic [DATA_W-1:0] mem_i [N_POINTS];
  logic [SW-1:0]     s;
  logic [L-2:0]      j;
  logic              inv_q, scale_q;
  logic              last_bfly;

  // Twiddle ROM, rounded to nearest at elaboration
  logic signed [TW_W-1:0] tw_cos [HALF];
  logic signed [TW_W-1:0] tw_sin [HALF];
  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam real CR = $cos(2.0 * PI * g / N_POINTS) * real'(1 << TW_FRAC);
    localparam real SR = $sin(2.0 * PI * g / N_POINTS) * real'(1 << TW_FRAC);
    assign tw_cos[g] = TW_W'(CR >= 0.0 ? $rtoi(CR + 0.5) : $rtoi(CR - 0.5));
    assign tw_sin[g] = TW_W'(SR >= 0.0 ? $rtoi(SR + 0.5) : $rtoi(SR - 0.5));
  end

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < L; b++) r[b] = v[L-1-b];
    return r;
  endfunction

  // Butterfly addressing: span = N >> (s+1), a = 2*(j - pos) + pos, b = a + span
  logic [L-1:0] span, pos, a_idx, b_idx;
  logic [L-2:0] k;
  always_comb begin
    span  = L'(HALF) >> s;
    pos   = L'(j) & (span - L'(1));
    a_idx = ((L'(j) & ~(span - L'(1))) << 1) | pos;
    b_idx = a_idx | span;
    k     = (L-1)'(pos << s);
  end

  logic signed [DATA_W-1:0] ar, ai, br, bi;
  logic signed [EW-1:0]     sr, si, dr, di, mr, mi, sa_r, sa_i, sb_r, sb_i;
  logic signed [TW_W-1:0]   wr, wi;
  logic signed [PW-1:0]     pr, pi;
  always_comb begin
    ar   = mem_r[a_idx];
    ai   = mem_i[a_idx];
    br   = mem_r[b_idx];
    bi   = mem_i[b_idx];
    sr   = EW'(ar) + EW'(br);
    si   = EW'(ai) + EW'(bi);
    dr   = EW'(ar) - EW'(br);
    di   = EW'(ai) - EW'(bi);
    wr   = tw_cos[k];
    wi   = inv_q ? tw_sin[k] : -tw_sin[k];
    pr   = PW'(dr) * PW'(wr) - PW'(di) * PW'(wi);
    pi   = PW'(dr) * PW'(wi) + PW'(di) * PW'(wr);
    mr   = EW'(pr >>> TW_FRAC);
    mi   = EW'(pi >>> TW_FRAC);
    sa_r = scale_q ? (sr >>> 1) : sr;
    sa_i = scale_q ? (si >>> 1) : si;
    sb_r = scale_q ? (mr >>> 1) : mr;
    sb_i = scale_q ? (mi >>> 1) : mi;
  end

  always_comb last_bfly = (s == SW'(L - 1)) && (j == '1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bfly) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s       <= '0;
      j       <= '0;
      inv_q   <= 1'b0;
      scale_q <= 1'b0;
      done    <= 1'b0;
      Real    <= '0;
      Imag    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          s       <= '0;
          j       <= '0;
          inv_q   <= inv;
          scale_q <= scale;
        end
        RUN: begin
          j <= j + (L-1)'(1);
          if (j == '1) s <= s + SW'(1);
        end
        OUT: begin
          done <= 1'b1;
          for (int unsigned i = 0; i < N_POINTS; i++) begin
            Real[i] <= mem_r[bitrev(L'(i))];
            Imag[i] <= mem_i[bitrev(L'(i))];
          end
        end
        default: ;
      endcase
    end
  end

  // Working memory carries no reset; it is always reloaded before use
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int unsigned i = 0; i < N_POINTS; i++) begin
        mem_r[i] <= data_in_R[i];
        mem_i[i] <= data_in_I[i];
      end
    end else if (state == RUN) begin
      mem_r[a_idx] <= DATA_W'(sa_r);
      mem_i[a_idx] <= DATA_W'(sa_i);
      mem_r[b_idx] <= DATA_W'(sb_r);
      mem_i[b_idx] <= DATA_W'(sb_i);
    end
  end

endmodule

// File: tb/tb_fft_dif_iter.sv
// Bench for fft_dif_iter at N=8, 16 and 64 against a double-precision DFT model.
module tb_fft_dif_iter;
  localparam int  DW  = 32;
  localparam int  TWF = 14;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst, inv, scale;
  logic [2:0] start_v;
  logic [63:0][DW-1:0] din_r, din_i;
  logic busy8, done8, busy16, done16, busy64, done64;
  logic [7:0][DW-1:0]  re8, im8;
  logic [15:0][DW-1:0] re16, im16;
  logic [63:0][DW-1:0] re64, im64;

  int  checks = 0;
  int  failures = 0;
  real ref_r [64];
  real ref_i [64];

  always #5 clk = ~clk;

  fft_dif_iter #(.N_POINTS(8), .DATA_W(DW), .TW_FRAC(TWF)) u_fft8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .inv(inv), .scale(scale),
    .data_in_R(din_r[7:0]), .data_in_I(din_i[7:0]),
    .busy(busy8), .done(done8), .Real(re8), .Imag(im8));

  fft_dif_iter #(.N_POINTS(16), .DATA_W(DW), .TW_FRAC(TWF)) u_fft16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .inv(inv), .scale(scale),
    .data_in_R(din_r[15:0]), .data_in_I(din_i[15:0]),
    .busy(busy16), .done(done16), .Real(re16), .Imag(im16));

  fft_dif_iter #(.N_POINTS(64), .DATA_W(DW), .TW_FRAC(TWF)) u_fft64 (
    .clk(clk), .rst(rst), .start(start_v[2]), .inv(inv), .scale(scale),
    .data_in_R(din_r), .data_in_I(din_i),
    .busy(busy64), .done(done64), .Real(re64), .Imag(im64));

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic int sel(input int n);
    return (n == 8) ? 0 : (n == 16) ? 1 : 2;
  endfunction

  function automatic longint get_re(input int n, input int i);
    case (n)
      8:       return longint'($signed(re8[i[2:0]]));
      16:      return longint'($signed(re16[i[3:0]]));
      default: return longint'($signed(re64[i[5:0]]));
    endcase
  endfunction

  function automatic longint get_im(input int n, input int i);
    case (n)
      8:       return longint'($signed(im8[i[2:0]]));
      16:      return longint'($signed(im16[i[3:0]]));
      default: return longint'($signed(im64[i[5:0]]));
    endcase
  endfunction

  function automatic longint get_busy(input int n);
    return (n == 8) ? longint'(busy8) : (n == 16) ? longint'(busy16) : longint'(busy64);
  endfunction

  function automatic longint get_done(input int n);
    return (n == 8) ? longint'(done8) : (n == 16) ? longint'(done16) : longint'(done64);
  endfunction

  function automatic longint nonzero_outs(input int n);
    longint c = 0;
    for (int i = 0; i < n; i++) if (get_re(n, i) != 0 || get_im(n, i) != 0) c++;
    return c;
  endfunction

  function automatic longint rnd(input real r);
    return (r >= 0.0) ? longint'($rtoi(r + 0.5)) : longint'($rtoi(r - 0.5));
  endfunction

  // Direct DFT: X[k] = sum x[m] e^(-+j 2 pi m k / n), optionally divided by n
  task automatic model(input int n, input bit iv, input bit sc);
    for (int k = 0; k < n; k++) begin
      real sr, si, xr, xi, ang;
      sr = 0.0;
      si = 0.0;
      for (int m = 0; m < n; m++) begin
        xr  = real'($signed(din_r[m]));
        xi  = real'($signed(din_i[m]));
        ang = 2.0 * PI * real'((m * k) % n) / real'(n);
        if (!iv) ang = -ang;
        sr += xr * $cos(ang) - xi * $sin(ang);
        si += xr * $sin(ang) + xi * $cos(ang);
      end
      if (sc) begin
        sr = sr / real'(n);
        si = si / real'(n);
      end
      ref_r[k] = sr;
      ref_i[k] = si;
    end
  endtask

  task automatic compare_all(input int n, input string name, input longint tol);
    for (int i = 0; i < n; i++) begin
      check($sformatf("N%0d_%s_re[%0d]", n, name, i), get_re(n, i), rnd(ref_r[i]), tol);
      check($sformatf("N%0d_%s_im[%0d]", n, name, i), get_im(n, i), rnd(ref_i[i]), tol);
    end
  endtask

  task automatic clear_in();
    din_r = '0;
    din_i = '0;
  endtask

  task automatic rand_fill(input int n);
    int v;
    clear_in();
    for (int i = 0; i < n; i++) begin
      v = int'($urandom_range(1024)) - 512;
      din_r[i] = DW'(v);
      v = int'($urandom_range(1024)) - 512;
      din_i[i] = DW'(v);
    end
  endtask

  // One frame; poke re-raises start (with other mode bits) mid-frame, which must be ignored
  task automatic run_frame(input int n, input bit iv, input bit sc, input bit poke,
                           input string name, input longint tol);
    int c, idx, cnt;
    bit busy_ok, seen;
    c   = (n / 2) * $clog2(n);
    idx = sel(n);
    inv = iv;
    scale = sc;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    inv = 1'b0;
    scale = 1'b0;
    busy_ok = (get_busy(n) == 1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < c + 20) begin
      if (poke && cnt == 4) begin
        start_v[idx] = 1'b1;
        inv = !iv;
        scale = !sc;
      end
      if (poke && cnt == 8) begin
        start_v = '0;
        inv = 1'b0;
        scale = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
      if (get_done(n) == 1) seen = 1'b1;
      else if (get_busy(n) != 1) busy_ok = 1'b0;
    end
    check($sformatf("N%0d_%s_busy_high", n, name), longint'(busy_ok), 1);
    check($sformatf("N%0d_%s_done_latency", n, name), seen ? longint'(cnt) : -1, c + 1);
    check($sformatf("N%0d_%s_busy_low_at_done", n, name), get_busy(n), 0);
    @(posedge clk); #1;
    check($sformatf("N%0d_%s_done_pulse", n, name), get_done(n), 0);
    model(n, iv, sc);
    compare_all(n, name, tol);
  endtask

  task automatic back_to_back(input int n);
    int c, idx, nd;
    int d [4];
    longint busy_acc;
    c   = (n / 2) * $clog2(n);
    idx = sel(n);
    nd  = 0;
    busy_acc = 0;
    for (int i = 0; i < 4; i++) d[i] = -1;
    rand_fill(n);
    inv = 1'b0;
    scale = 1'b0;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    for (int cnt = 1; cnt <= 3 * (c + 2) + 2; cnt++) begin
      @(posedge clk); #1;
      if (cnt == 2 * (c + 2)) begin
        start_v = '0;
        busy_acc = get_busy(n);
      end
      if (get_done(n) == 1) begin
        if (nd < 4) d[nd] = cnt;
        nd++;
      end
    end
    check($sformatf("N%0d_b2b_third_accept", n), busy_acc, 1);
    check($sformatf("N%0d_b2b_done_count", n), longint'(nd), 3);
    check($sformatf("N%0d_b2b_done0", n), longint'(d[0]), c + 1);
    check($sformatf("N%0d_b2b_done1", n), longint'(d[1]), 2 * c + 3);
    check($sformatf("N%0d_b2b_done2", n), longint'(d[2]), 3 * c + 5);
    model(n, 1'b0, 1'b0);
    compare_all(n, "b2b", n / 2 + 2);
  endtask

  task automatic reset_mid(input int n);
    int idx;
    idx = sel(n);
    rand_fill(n);
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check($sformatf("N%0d_midrst_busy", n), get_busy(n), 0);
    check($sformatf("N%0d_midrst_done", n), get_done(n), 0);
    check($sformatf("N%0d_midrst_outs_nonzero", n), nonzero_outs(n), 0);
    rst = 1'b0;
  endtask

  initial begin
    int sizes [3];
    int n, l;
    sizes = '{8, 16, 64};
    rst = 1'b1;
    start_v = '0;
    inv = 1'b0;
    scale = 1'b0;
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("N%0d_reset_busy", sizes[t]), get_busy(sizes[t]), 0);
      check($sformatf("N%0d_reset_done", sizes[t]), get_done(sizes[t]), 0);
      check($sformatf("N%0d_reset_outs_nonzero", sizes[t]), nonzero_outs(sizes[t]), 0);
    end
    rst = 1'b0;

    for (int t = 0; t < 3; t++) begin
      n = sizes[t];
      l = $clog2(n);

      clear_in();
      din_r[0] = DW'(100);
      run_frame(n, 1'b0, 1'b0, 1'b0, "impulse", 0);

      clear_in();
      for (int i = 0; i < n; i++) din_r[i] = DW'(16);
      run_frame(n, 1'b0, 1'b0, 1'b0, "dc", 0);
      check($sformatf("N%0d_dc_x0", n), get_re(n, 0), 16 * n);

      clear_in();
      for (int i = 0; i < n; i++) begin
        din_r[i] = DW'(16 * i);
        din_i[i] = DW'(-16 * i);
      end
      run_frame(n, 1'b0, 1'b0, 1'b0, "ramp", (n == 8) ? 2 : n / 2 + 2);
      check($sformatf("N%0d_ramp_x0_re", n), get_re(n, 0), 8 * n * (n - 1));
      check($sformatf("N%0d_ramp_x0_im", n), get_im(n, 0), -8 * n * (n - 1));

      clear_in();
      for (int i = 0; i < n; i++) din_r[i] = DW'(100);
      run_frame(n, 1'b1, 1'b0, 1'b0, "roundtrip", 1);
      run_frame(n, 1'b1, 1'b1, 1'b0, "roundtrip_scaled", 1);

      rand_fill(n);
      run_frame(n, 1'b0, 1'b0, 1'b1, "rnd_fwd_poke", n / 2 + 2);
      rand_fill(n);
      run_frame(n, 1'b1, 1'b0, 1'b0, "rnd_inv", n / 2 + 2);
      rand_fill(n);
      run_frame(n, 1'b0, 1'b1, 1'b0, "rnd_scaled", 2 * l + 2);

      back_to_back(n);

      reset_mid(n);
      rand_fill(n);
      run_frame(n, 1'b1, 1'b1, 1'b0, "post_reset", 2 * l + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_dif_iter.md
# fft_dif_iter

Parametrised iterative radix-2 decimation-in-frequency FFT/IFFT core: the next generation of our fixed 8-point parallel FFT_TOP. It captures N complex samples in parallel on `start`, computes the transform in place with a single time-shared butterfly over log2(N) stages, and presents bit-reversal-corrected results in natural order with a one-cycle `done` pulse. It adds three things the 8-point block lacks: arbitrary power-of-two size, a runtime inverse mode and optional per-stage scaling.

## Interface
- `N_POINTS`, 8: transform size; power of two, 4..64.
- `DATA_W`, 32: two's-complement width of every real/imaginary sample, internal word and output.
- `TW_FRAC`, 14: fractional bits of the twiddle factors (signed Q1.TW_FRAC, width TW_FRAC+2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request; accepted only in IDLE.
- `inv` in 1: 1 = inverse transform; sampled with `start`.
- `scale` in 1: 1 = divide by 2 at every stage; sampled with `start`.
- `data_in_R` in [N_POINTS-1:0][DATA_W]: real inputs, natural order, index 0 = x[0].
- `data_in_I` in [N_POINTS-1:0][DATA_W]: imaginary inputs.
- `busy` out 1: high from accepted `start` until the results are written.
- `done` out 1: one-cycle pulse, results valid.
- `Real` out [N_POINTS-1:0][DATA_W]: real outputs, natural order X[0..N-1].
- `Imag` out [N_POINTS-1:0][DATA_W]: imaginary outputs.

## Operation
- FSM: IDLE -> RUN -> OUT -> IDLE.
- IDLE: on `start`=1, copy the inputs into working memory `mem[0..N-1]`, latch `inv`/`scale`, clear stage counter s and butterfly counter j, and go to RUN.
- RUN: one butterfly per cycle. With L=log2(N) and span = N>>(s+1): pos = j mod span, a = (j/span)·2·span + pos, b = a+span, twiddle index k = pos<<s.
- DIF butterfly: mem[a] <= A+B; mem[b] <= (A−B)·W^k. W^k = cos(2πk/N) − j·sin(2πk/N); when `inv`=1 use the conjugate.
- Twiddle ROM: N/2 entries, round(cos·2^TW_FRAC) and round(sin·2^TW_FRAC), computed at elaboration.
- Complex product: full-precision products and sums, arithmetic right shift by TW_FRAC (truncation), truncated to DATA_W.
- Scale: when `scale`=1, both butterfly results are arithmetic-shifted right by 1 after the add/sub and the multiply. No saturation anywhere; overflow wraps (two's complement).
- The inverse applies no 1/N normalisation unless `scale`=1.
- j counts 0..N/2−1; on wrap, s increments. After the last butterfly (s=L−1, j=N/2−1), go to OUT.
- OUT: Real[i]/Imag[i] <= mem[bitrev(i)], pulse `done`, return to IDLE.
- `start` while in RUN or OUT is ignored (not queued). `Real`/`Imag` hold their values until the next OUT.
- `rst` at any time: state goes to IDLE and counters to 0. `busy`, `done`, `Real` and `Imag` all reset to 0. A frame in flight is discarded.

## Timing
- Start sampled at edge t0. Butterflies execute at edges t0+1 .. t0+C, where C = (N/2)·log2(N).
- Outputs and `done` are registered at edge t0+C+1. For N=8: C=12, done at t0+13.
- `busy` is high after edges t0 .. t0+C and low after t0+C+1, in the same cycle that `done` is high.
- Back-to-back: with `start` held high, the next frame is accepted at t0+C+2, one frame every C+2 cycles.
- Each butterfly reads and writes mem in the same cycle. A stage's reads never depend on that stage's writes.

## Test plan
- Impulse, N=8, x[0]=100+0j, others 0, inv=0, scale=0 -> every X[k]=100+0j; `done` exactly 13 cycles after the start edge; `busy` is high for those 13 cycles.
- DC, all x[n]=16+0j -> X[0]=128+0j and X[1..7]=0 (exact).
- Ramp x[n]=16n − j·16n (n=0..7) -> X[0]=448−448j. All bins within ±2 LSB of a double-precision DFT model truncated to DATA_W.
- Round-trip: feed X[k]=100+0j for all k with inv=1, scale=0 -> x[0]=800, all others 0 (±1 LSB). Repeat with scale=1 -> x[0]=100.
- Handshake: hold `start`=1 continuously for 3 frames -> frames accepted at t0, t0+14 and t0+28, with 3 `done` pulses. Then reassert `start` at t0+5 of a new frame -> no effect on that frame's outputs or timing.
- Reset mid-run: assert `rst` at t0+6 -> next cycle `busy`=0, `done`=0, all outputs 0. A new `start` afterwards completes normally. Repeat the suite for N=16 (C=32, done at t0+33) and N=64.
